// File: rtl/adder_pkg.sv
// adder_pkg: shared word width, sequencer state type and index-width helper
package adder_pkg;
  localparam int WORD_W = 16;
  typedef enum logic {IDLE, BUSY} state_t;
  function automatic int cnt_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mw_add_seq_if.sv
// mw_add_seq_if: operand-word input stream and sum-word output stream of the sequencer
// master: upstream/downstream side (drives in_*, op_cin, out_ready); slave: the sequencer
interface mw_add_seq_if
  import adder_pkg::*;
#(
  parameter int MAX_WORDS = 4,
  parameter int CNT_W     = cnt_w(MAX_WORDS)
);
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_a;
  logic [WORD_W-1:0] in_b;
  logic              in_last;
  logic              op_cin;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_sum;
  logic [CNT_W-1:0]  out_idx;
  logic              out_last;
  logic              out_cout;
  logic              out_overflow;
  logic              err_len;
  modport master (
    output in_valid, in_a, in_b, in_last, op_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_idx, out_last, out_cout, out_overflow, err_len
  );
  modport slave (
    input  in_valid, in_a, in_b, in_last, op_cin, out_ready,
    output in_ready, out_valid, out_sum, out_idx, out_last, out_cout, out_overflow, err_len
  );
endinterface

// File: rtl/adder_16bit.sv
// adder_16bit: one word of the chained add, with carry-out and signed overflow
// ports: a, b, cin in; sum, cout, overflow out
module adder_16bit
  import adder_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W-1:0] sum,
  output logic              cout,
  output logic              overflow
);
  assign {cout, sum} = a + b + {{WORD_W{1'b0}}, cin};
  assign overflow = (a[WORD_W-1] == b[WORD_W-1]) && (sum[WORD_W-1] != a[WORD_W-1]);
endmodule

// File: rtl/mw_add_seq.sv
// mw_add_seq: multi-word add sequencer chaining adder_16bit carries into a registered sum stream
// ports: clk, rst (async active-high), bus (mw_add_seq_if.slave: operand stream in, sum stream out, sticky err_len)
module mw_add_seq
  import adder_pkg::*;
#(
  parameter int MAX_WORDS = 4
) (
  input logic         clk,
  input logic         rst,
  mw_add_seq_if.slave bus
);
  localparam int CNT_W = cnt_w(MAX_WORDS);
  state_t            r_state;
  logic              r_carry;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_valid;
  logic [WORD_W-1:0] r_sum;
  logic [CNT_W-1:0]  r_idx;
  logic              r_last;
  logic              r_cout;
  logic              r_ovf;
  logic              r_err;
  logic              w_acc;
  logic              w_cin;
  logic [CNT_W-1:0]  w_idx;
  logic              w_full;
  logic              w_last;
  logic [WORD_W-1:0] w_sum;
  logic              w_cout;
  logic              w_ovf;
  assign bus.in_ready = !rst && (!r_valid || bus.out_ready);
  assign w_acc  = bus.in_valid && bus.in_ready;
  assign w_cin  = (r_state == IDLE) ? bus.op_cin : r_carry;
  assign w_idx  = (r_state == IDLE) ? '0 : r_cnt;
  // in IDLE the index is 0, so this also covers a single-word MAX_WORDS
  assign w_full = (w_idx == CNT_W'(MAX_WORDS - 1));
  assign w_last = bus.in_last || w_full;
  adder_16bit u_add (
    .a(bus.in_a), .b(bus.in_b), .cin(w_cin),
    .sum(w_sum), .cout(w_cout), .overflow(w_ovf)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_last  <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_err   <= 1'b0;
    end else if (w_acc) begin
      r_state <= w_last ? IDLE : BUSY;
      r_carry <= !w_last && w_cout;
      r_cnt   <= w_last ? '0 : CNT_W'(w_idx + 1'b1);
      r_valid <= 1'b1;
      r_sum   <= w_sum;
      r_idx   <= w_idx;
      r_last  <= w_last;
      r_cout  <= w_last && w_cout;
      r_ovf   <= w_last && w_ovf;
      if (w_full && !bus.in_last) r_err <= 1'b1;
    end else if (bus.out_ready) begin
      r_valid <= 1'b0;
    end
  end
  assign bus.out_valid    = r_valid;
  assign bus.out_sum      = r_sum;
  assign bus.out_idx      = r_idx;
  assign bus.out_last     = r_last;
  assign bus.out_cout     = r_cout;
  assign bus.out_overflow = r_ovf;
  assign bus.err_len      = r_err;
endmodule

// File: doc/mw_add_seq.md
Name: mw_add_seq

Overview:
- Multi-word add sequencer that sits directly upstream of adder_16bit and also consumes its outputs.
- Accepts a stream of 16-bit operand word pairs, least-significant word first, and drives adder_16bit a/b/cin per word.
- Chains cout into the next word's cin and emits a registered stream of sum words.
- On the final word it reports the final carry and the signed overflow of the full multi-word add.

Parameters:
- MAX_WORDS, 4, maximum words per operation; an operation is force-terminated at this count.
- CNT_W, $clog2(MAX_WORDS) (min 1), width of the word index.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  operand word pair valid.
- in_ready  out  1  sequencer can accept a word this cycle.
- in_a  in  16  operand A word.
- in_b  in  16  operand B word.
- in_last  in  1  this is the most-significant word of the operation.
- op_cin  in  1  carry-in of the operation; sampled only on the first word.
- out_valid  out  1  result word valid.
- out_ready  in  1  downstream accepts the result word.
- out_sum  out  16  sum word.
- out_idx  out  CNT_W  word index within the operation (0 = LSW).
- out_last  out  1  final word of the operation.
- out_cout  out  1  final carry-out; 0 on non-last beats.
- out_overflow  out  1  signed overflow of the whole operation; 0 on non-last beats.
- err_len  out  1  sticky: an operation hit MAX_WORDS without in_last.

Behaviour:
- Accept (input handshake): in_valid && in_ready.
  - in_ready = !rst && (!out_valid || out_ready). This is a single output register with no skid buffer.
- Output handshake: out_valid && out_ready.
- FSM has two states:
  - IDLE: expecting the first word.
  - BUSY: mid-operation.
- IDLE on accept:
  - adder cin = op_cin; idx = 0.
  - If in_last, or MAX_WORDS == 1, stay in IDLE.
  - Otherwise go to BUSY; carry_q <= adder cout; cnt <= 1.
- BUSY on accept:
  - adder cin = carry_q; idx = cnt.
  - If in_last, or cnt == MAX_WORDS-1, go to IDLE.
  - Otherwise carry_q <= cout; cnt <= cnt+1.
- Forced termination: when cnt == MAX_WORDS-1 and in_last = 0:
  - Beat is emitted with out_last = 1.
  - err_len <= 1, held until rst.
  - The next word starts a new operation using op_cin.
- Latency: a word accepted in cycle N produces out_valid in cycle N+1.
  - out_sum, out_idx, out_last, out_cout and out_overflow are registered from adder outputs in the same accept cycle.
- out_cout and out_overflow:
  - On a last beat: adder cout and overflow of that word. overflow = (a[15]==b[15]) && (sum[15]!=a[15]).
  - Otherwise: 0.
- While out_valid && !out_ready, all out_* hold stable and no input is accepted.
- Accept and output-consume in the same cycle are allowed: the register reloads with the new beat, giving full throughput.
- No input accepted → carry_q, cnt and FSM state unchanged.
- Reset (asynchronous, any time, including mid-operation):
  - out_valid = 0, out_sum = 0, out_idx = 0, out_last = 0, out_cout = 0, out_overflow = 0, err_len = 0.
  - FSM = IDLE, carry_q = 0, cnt = 0.
  - A partially accumulated operation is discarded; no partial beat is emitted after reset.
- Arithmetic: unsigned 16-bit per word with carry chaining. Signed interpretation applies to the full MAX-width result only via out_overflow on the last word.

Decomposition:
- Shared package adder_pkg: WORD_W = 16; FSM state typedef {IDLE, BUSY}.
- Sub-module: one instance of adder_16bit (a, b, cin, sum, cout, overflow). Its cin is driven by the mux (IDLE ? op_cin : carry_q).
- The rest fits in a single module: FSM, counter, carry register and output register.

Test Plan:
1. Single word: in_a=7FFF, in_b=0001, op_cin=0, in_last=1 → one cycle later out_sum=8000, out_idx=0, out_last=1, out_cout=0, out_overflow=1.
2. Two-word carry chain: (FFFF,0001,last=0), (0000,0000,last=1), op_cin=0 → beats {0000, idx0, last0, cout0, ovf0} then {0001, idx1, last1, cout0, ovf0}.
3. Three-word all-ones with cin: (FFFF,0000) ×3, op_cin=1, last on word 3 → sums 0000, 0000, 0000; final out_cout=1, out_overflow=0.
4. Backpressure: hold out_ready=0 for 3 cycles after the first beat → in_ready=0, out_* stable for those 3 cycles. With out_ready=1 and in_valid=1 every cycle → one beat per cycle.
5. Length error (MAX_WORDS=4): send 5 words with in_last=0 → beat idx3 has out_last=1 and err_len=1 thereafter. The 5th word produces idx0 using op_cin.
6. Reset mid-operation: accept word 0 of (FFFF+0001), pulse rst asynchronously → out_valid=0, err_len=0 immediately. Next word (0000,0000,last=1,op_cin=0) → out_sum=0000, idx0 (no stale carry).
